// File: rtl/placement_reader_if.sv
// Read ports onto the shared grid / pos_X / pos_Y RAMs plus the outgoing record stream.
interface placement_reader_if;
   logic               grid_rd;
   logic signed [31:0] grid_addr;
   logic signed [31:0] grid_dout;
   logic               pos_rd;
   logic signed [31:0] pos_addr;
   logic signed [31:0] pos_x_dout;
   logic signed [31:0] pos_y_dout;
   logic               o_valid;
   logic               o_ready;
   logic signed [31:0] o_node;
   logic        [31:0] o_x;
   logic        [31:0] o_y;
   logic               o_match;

   modport master (
      output grid_rd, grid_addr, pos_rd, pos_addr,
      output o_valid, o_node, o_x, o_y, o_match,
      input  grid_dout, pos_x_dout, pos_y_dout, o_ready
   );

   modport slave (
      input  grid_rd, grid_addr, pos_rd, pos_addr,
      input  o_valid, o_node, o_x, o_y, o_match,
      output grid_dout, pos_x_dout, pos_y_dout, o_ready
   );
endinterface

// File: rtl/placement_reader.sv
// Scans a finished placement grid, checks each node's pos_X/pos_Y against its cell
// and streams one record per placed node.
//
// state  | meaning
// IDLE   | waiting for start
// G_RD   | grid read strobe for cell c
// G_WAIT | grid read latency
// G_CHK  | classify grid word: empty, bad id, or node
// P_RD   | pos_X/pos_Y read strobe for node
// P_WAIT | pos read latency
// P_CHK  | compare positions against the scan coordinates
// EMIT   | record offered until transfer
// NEXT   | advance cell or finish
module placement_reader #(
   parameter int N      = 7,
   parameter int V      = 11,
   parameter int EMPTY  = -1,
   parameter int RD_LAT = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [31:0]         n_placed,
   output logic [31:0]         n_errors,
   placement_reader_if.master  bus
);

   typedef enum logic [3:0] {
      IDLE, G_RD, G_WAIT, G_CHK, P_RD, P_WAIT, P_CHK, EMIT, NEXT
   } state_t;

   localparam logic        [31:0] LAST      = 32'(N * N - 1);
   localparam logic        [31:0] Y_MAX     = 32'(N - 1);
   localparam logic signed [31:0] EMPTY_S   = 32'(EMPTY);
   localparam logic signed [31:0] V_S       = 32'(V);
   localparam logic        [7:0]  WAIT_LOAD = 8'(RD_LAT - 2);

   state_t      state, state_nxt;
   logic [31:0] c, x, y;
   logic [7:0]  wait_cnt;
   logic        empty_cell, bad_id, pos_match;

   assign empty_cell = (bus.grid_dout == EMPTY_S);
   assign bad_id     = (bus.grid_dout < 0) || (bus.grid_dout >= V_S);
   assign pos_match  = (bus.pos_x_dout == $signed(x)) && (bus.pos_y_dout == $signed(y));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !done) state_nxt = G_RD;
         G_RD:    state_nxt = G_WAIT;
         G_WAIT:  if (wait_cnt == 8'd0) state_nxt = G_CHK;
         G_CHK:   state_nxt = (empty_cell || bad_id) ? NEXT : P_RD;
         P_RD:    state_nxt = P_WAIT;
         P_WAIT:  if (wait_cnt == 8'd0) state_nxt = P_CHK;
         P_CHK:   state_nxt = EMIT;
         EMIT:    if (bus.o_ready) state_nxt = NEXT;
         NEXT:    state_nxt = (c == LAST) ? IDLE : G_RD;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.grid_rd = (state == G_RD);
      bus.pos_rd  = (state == P_RD);
      bus.o_valid = (state == EMIT);
   end

   // Addresses are loaded only when an access begins so they hold between accesses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy          <= 1'b0;
         done          <= 1'b0;
         n_placed      <= '0;
         n_errors      <= '0;
         c             <= '0;
         x             <= '0;
         y             <= '0;
         wait_cnt      <= '0;
         bus.grid_addr <= '0;
         bus.pos_addr  <= '0;
         bus.o_node    <= '0;
         bus.o_x       <= '0;
         bus.o_y       <= '0;
         bus.o_match   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !done) begin
                  busy          <= 1'b1;
                  n_placed      <= '0;
                  n_errors      <= '0;
                  c             <= '0;
                  x             <= '0;
                  y             <= '0;
                  bus.grid_addr <= '0;
               end
            end
            G_RD, P_RD: wait_cnt <= WAIT_LOAD;
            G_WAIT, P_WAIT: begin
               if (wait_cnt != 8'd0) wait_cnt <= wait_cnt - 8'd1;
            end
            G_CHK: begin
               if (!empty_cell) begin
                  if (bad_id) begin
                     n_errors <= n_errors + 32'd1;
                  end else begin
                     bus.o_node   <= bus.grid_dout;
                     bus.pos_addr <= bus.grid_dout;
                  end
               end
            end
            P_CHK: begin
               bus.o_x     <= x;
               bus.o_y     <= y;
               bus.o_match <= pos_match;
               if (!pos_match) n_errors <= n_errors + 32'd1;
            end
            EMIT: begin
               if (bus.o_ready) n_placed <= n_placed + 32'd1;
            end
            NEXT: begin
               if (c == LAST) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end else begin
                  c             <= c + 32'd1;
                  bus.grid_addr <= $signed(c + 32'd1);
                  if (y == Y_MAX) begin
                     y <= '0;
                     x <= x + 32'd1;
                  end else begin
                     y <= y + 32'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_placement_reader.sv
// Directed bench for placement_reader: RAM models with two-cycle read latency,
// a stallable consumer and a record monitor.
module tb_placement_reader;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        busy, done;
   logic [31:0] n_placed, n_errors;

   placement_reader_if bus();

   placement_reader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .n_placed (n_placed),
      .n_errors (n_errors),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   logic signed [31:0] grid_mem [49];
   logic signed [31:0] pos_x_mem [11];
   logic signed [31:0] pos_y_mem [11];
   logic signed [31:0] g1, px1, py1;

   // Strobe + one wait cycle: data is valid two cycles after the strobe cycle.
   always @(posedge clk) begin
      if (bus.grid_rd && bus.grid_addr >= 0 && bus.grid_addr < 49)
         g1 <= grid_mem[int'(bus.grid_addr)];
      if (bus.pos_rd && bus.pos_addr >= 0 && bus.pos_addr < 11) begin
         px1 <= pos_x_mem[int'(bus.pos_addr)];
         py1 <= pos_y_mem[int'(bus.pos_addr)];
      end
      bus.grid_dout  <= g1;
      bus.pos_x_dout <= px1;
      bus.pos_y_dout <= py1;
   end

   int stall_mode = 0;
   int stall_cnt  = 0;
   initial begin
      bus.o_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bus.o_valid) begin
            if (stall_mode != 0 && stall_cnt < 5) begin
               bus.o_ready = 1'b0;
               stall_cnt++;
            end else begin
               bus.o_ready = 1'b1;
            end
         end else begin
            stall_cnt = 0;
            bus.o_ready = (stall_mode == 0);
         end
      end
   end

   int n_grid_rd, n_pos_rd, n_overlap, n_xfer, n_unstable;
   int rec_node [8];
   int rec_x [8];
   int rec_y [8];
   int rec_m [8];
   logic        stalled = 1'b0;
   logic [31:0] snap_node, snap_x, snap_y;
   logic        snap_m;

   always @(negedge clk) begin
      if (bus.grid_rd) n_grid_rd++;
      if (bus.pos_rd) n_pos_rd++;
      if (bus.grid_rd && bus.pos_rd) n_overlap++;
      if (bus.o_valid && stalled &&
          (bus.o_node != snap_node || bus.o_x != snap_x || bus.o_y != snap_y || bus.o_match != snap_m))
         n_unstable++;
      if (bus.o_valid && bus.o_ready) begin
         if (n_xfer < 8) begin
            rec_node[n_xfer] = int'(bus.o_node);
            rec_x[n_xfer]    = int'(bus.o_x);
            rec_y[n_xfer]    = int'(bus.o_y);
            rec_m[n_xfer]    = int'(bus.o_match);
         end
         n_xfer++;
      end
      stalled   = bus.o_valid && !bus.o_ready;
      snap_node = bus.o_node;
      snap_x    = bus.o_x;
      snap_y    = bus.o_y;
      snap_m    = bus.o_match;
   end

   task automatic clear_mem();
      for (int i = 0; i < 49; i++) grid_mem[i] = -32'sd1;
      for (int i = 0; i < 11; i++) begin
         pos_x_mem[i] = -32'sd1;
         pos_y_mem[i] = -32'sd1;
      end
   endtask

   task automatic clear_mon();
      @(posedge clk);
      #1;
      n_grid_rd = 0; n_pos_rd = 0; n_overlap = 0; n_xfer = 0; n_unstable = 0;
   endtask

   // Returns clock edges from the accepting edge until done is seen.
   task automatic run_scan(output int cyc);
      clear_mon();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 0;
      while (!done && cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   int cyc, k;

   initial begin
      clear_mem();
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_grid_rd", bus.grid_rd, 0);
      chk("rst_pos_rd", bus.pos_rd, 0);
      chk("rst_n_placed", n_placed, 0);
      chk("rst_n_errors", n_errors, 0);
      @(negedge clk) reset = 1'b0;

      // 1: empty grid
      run_scan(cyc);
      chk("t1_cycles", cyc, 196);
      chk("t1_n_placed", n_placed, 0);
      chk("t1_n_errors", n_errors, 0);
      chk("t1_xfer", n_xfer, 0);
      chk("t1_grid_rds", n_grid_rd, 49);
      chk("t1_pos_rds", n_pos_rd, 0);
      chk("t1_busy_at_done", busy, 0);

      // 2: node 3 at cell 10, node 10 (last id) at last cell
      clear_mem();
      grid_mem[10] = 3;  pos_x_mem[3] = 1;  pos_y_mem[3] = 3;
      grid_mem[48] = 10; pos_x_mem[10] = 6; pos_y_mem[10] = 6;
      run_scan(cyc);
      chk("t2_cycles", cyc, 204);
      chk("t2_n_placed", n_placed, 2);
      chk("t2_n_errors", n_errors, 0);
      chk("t2_xfer", n_xfer, 2);
      chk("t2_r0_node", rec_node[0], 3);
      chk("t2_r0_x", rec_x[0], 1);
      chk("t2_r0_y", rec_y[0], 3);
      chk("t2_r0_match", rec_m[0], 1);
      chk("t2_r1_node", rec_node[1], 10);
      chk("t2_r1_x", rec_x[1], 6);
      chk("t2_r1_y", rec_y[1], 6);
      chk("t2_r1_match", rec_m[1], 1);
      chk("t2_pos_rds", n_pos_rd, 2);
      chk("t2_overlap", n_overlap, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t2_hold_placed", n_placed, 2);
      chk("t2_done_pulse", done, 0);

      // 3: position mismatch
      clear_mem();
      grid_mem[0] = 5; pos_x_mem[5] = 2; pos_y_mem[5] = 0;
      run_scan(cyc);
      chk("t3_cycles", cyc, 200);
      chk("t3_xfer", n_xfer, 1);
      chk("t3_r0_node", rec_node[0], 5);
      chk("t3_r0_x", rec_x[0], 0);
      chk("t3_r0_y", rec_y[0], 0);
      chk("t3_r0_match", rec_m[0], 0);
      chk("t3_n_errors", n_errors, 1);
      chk("t3_n_placed", n_placed, 1);

      // 4: out-of-range ids (11 and negative)
      clear_mem();
      grid_mem[0] = 11;
      grid_mem[20] = -2;
      run_scan(cyc);
      chk("t4_cycles", cyc, 196);
      chk("t4_pos_rds", n_pos_rd, 0);
      chk("t4_xfer", n_xfer, 0);
      chk("t4_n_errors", n_errors, 2);
      chk("t4_n_placed", n_placed, 0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("t4_start_on_done_busy", busy, 0);
      chk("t4_start_on_done_rd", bus.grid_rd, 0);

      // 5: consumer stalls for 5 cycles
      clear_mem();
      grid_mem[10] = 3; pos_x_mem[3] = 1; pos_y_mem[3] = 3;
      stall_mode = 1;
      run_scan(cyc);
      stall_mode = 0;
      chk("t5_cycles", cyc, 205);
      chk("t5_unstable", n_unstable, 0);
      chk("t5_xfer", n_xfer, 1);
      chk("t5_n_placed", n_placed, 1);
      chk("t5_r0_node", rec_node[0], 3);

      // 6: reset while waiting on the pos read
      clear_mem();
      grid_mem[0] = 11;
      grid_mem[10] = 3; pos_x_mem[3] = 1; pos_y_mem[3] = 3;
      clear_mon();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      k = 0;
      while (!bus.pos_rd && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("t6_pos_rd_seen", bus.pos_rd, 1);
      @(posedge clk);
      #1;
      chk("t6_err_before", n_errors, 1);
      reset = 1'b1;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_valid", bus.o_valid, 0);
      chk("t6_pos_rd", bus.pos_rd, 0);
      chk("t6_n_errors", n_errors, 0);
      chk("t6_pos_addr", bus.pos_addr, 0);
      chk("t6_o_node", bus.o_node, 0);
      @(negedge clk);
      @(negedge clk) reset = 1'b0;
      run_scan(cyc);
      chk("t6_cycles", cyc, 200);
      chk("t6_n_placed", n_placed, 1);
      chk("t6_n_errors_rerun", n_errors, 1);
      chk("t6_xfer", n_xfer, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
